// File: rtl/gp_sum_stage.sv
// gp_sum_stage
// Two-stage registered sum/carry stage that sits directly after the 16-bit
// prefix group generate/propagate network of the parallel-prefix adder.
// Stage 1 registers the incoming p/G/P/cin vector.
// Stage 2 registers the sum, carry-out and signed overflow derived from it.
// Both stages use a valid/ready handshake with full backpressure.
// A wrapping counter tallies results accepted downstream.
// Optional build macro: FLAGS_EN adds registered out_zero/out_neg flags.
module gp_sum_stage #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH:1]   in_p,
  input  logic [WIDTH:1]   in_G,
  input  logic [WIDTH:1]   in_P,
  input  logic             in_cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:1]   out_sum,
  output logic             out_cout,
  output logic             out_ovf,
  output logic [CNT_W-1:0] op_count
`ifdef FLAGS_EN
  ,
  output logic             out_zero,
  output logic             out_neg
`endif
);

  // Stage 1 holding registers
  logic             s1_valid;
  logic [WIDTH:1]   s1_p;
  logic [WIDTH:1]   s1_G;
  logic [WIDTH:1]   s1_P;
  logic             s1_cin;

  // Stage 2 occupancy and the handshake term derived from it
  logic             s2_valid;
  logic             s2_acc;

  // Combinational result computed from stage 1 contents
  logic [WIDTH:1]   carry;
  logic [WIDTH:1]   sum_c;
  logic             cout_c;
  logic             ovf_c;

  // Stage 2 can take a new entry when it is empty or its result leaves now.
  // Stage 1 can take one when it is empty or it hands its entry to stage 2.
  // in_ready is held low during reset and flush, never depends on in_valid.
  always_comb begin
    s2_acc   = ~s2_valid | out_ready;
    in_ready = rst_n & ~flush & (~s1_valid | s2_acc);
  end

  assign out_valid = s2_valid;

  // Carries come straight from the prefix group terms: carry into bit i is
  // the group generate of bits i-1..1, or its group propagate with cin.
  always_comb begin
    carry    = '0;
    carry[1] = s1_cin;
    for (int i = 2; i <= WIDTH; i++) begin
      carry[i] = s1_G[i-1] | (s1_P[i-1] & s1_cin);
    end
    sum_c  = s1_p ^ carry;
    cout_c = s1_G[WIDTH] | (s1_P[WIDTH] & s1_cin);
    ovf_c  = carry[WIDTH] ^ cout_c;
  end

  // Stage 1 occupancy: flush empties it, otherwise it follows in_valid on accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
    end else if (flush) begin
      s1_valid <= 1'b0;
    end else if (in_ready) begin
      s1_valid <= in_valid;
    end
  end

  // Stage 1 data is only captured on an accepted input and needs no reset.
  always_ff @(posedge clk) begin
    if (in_valid && in_ready) begin
      s1_p   <= in_p;
      s1_G   <= in_G;
      s1_P   <= in_P;
      s1_cin <= in_cin;
    end
  end

  // Stage 2 occupancy: flush empties it, otherwise it advances when allowed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
    end else if (flush) begin
      s2_valid <= 1'b0;
    end else if (s2_acc) begin
      s2_valid <= s1_valid;
    end
  end

  // Stage 2 result registers load only when a real entry moves forward,
  // so the presented result stays stable under backpressure.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_sum  <= '0;
      out_cout <= 1'b0;
      out_ovf  <= 1'b0;
    end else if (s2_acc && s1_valid) begin
      out_sum  <= sum_c;
      out_cout <= cout_c;
      out_ovf  <= ovf_c;
    end
  end

`ifdef FLAGS_EN
  // Zero/negative flags ride along with the sum register at the same latency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_zero <= 1'b0;
      out_neg  <= 1'b0;
    end else if (s2_acc && s1_valid) begin
      out_zero <= (sum_c == '0);
      out_neg  <= sum_c[WIDTH];
    end
  end
`endif

  // Completed-operation counter: counts every downstream handshake, even in a
  // flush cycle, and wraps naturally at 2^CNT_W.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_count <= '0;
    end else if (s2_valid && out_ready) begin
      op_count <= op_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_gp_sum_stage.sv
// tb_gp_sum_stage
// Randomized and directed bench for gp_sum_stage.
// The reference model adds the operands as integers and queues the results.
// Build with FLAGS_EN defined to also exercise out_zero/out_neg.
module tb_gp_sum_stage;

  localparam int WIDTH = 16;
  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH:1]   in_p;
  logic [WIDTH:1]   in_G;
  logic [WIDTH:1]   in_P;
  logic             in_cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH:1]   out_sum;
  logic             out_cout;
  logic             out_ovf;
  logic [CNT_W-1:0] op_count;
`ifdef FLAGS_EN
  logic             out_zero;
  logic             out_neg;
`endif

  gp_sum_stage #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_p      (in_p),
    .in_G      (in_G),
    .in_P      (in_P),
    .in_cin    (in_cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_cout  (out_cout),
    .out_ovf   (out_ovf),
    .op_count  (op_count)
`ifdef FLAGS_EN
    ,
    .out_zero  (out_zero),
    .out_neg   (out_neg)
`endif
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
    logic        zero;
    logic        neg;
    int          cyc;
  } exp_t;

  exp_t             sb[$];
  int               total = 0;
  int               bad   = 0;
  int               cyc   = 0;
  logic [CNT_W-1:0] exp_count;
  logic [15:0]      cur_a;
  logic [15:0]      cur_b;
  logic             cur_cin;
  bit               strict_lat;
  logic             held_valid;
  logic [15:0]      held_sum;
  logic             held_cout;
  logic             held_ovf;
  logic             last_in_ready;
  logic             last_out_valid;

  // Single comparison point: counts and reports every check
  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("[TB] FAIL %s: got=%0h want=%0h", tag, got, want);
    end
  endtask

  // Upstream prefix network: bit p/g from the operands, then group G/P over bits i..1
  function automatic void derive(input logic [15:0] a, input logic [15:0] b,
                                 output logic [16:1] p, output logic [16:1] gg,
                                 output logic [16:1] pp);
    logic gi, pi, gacc, pacc;
    gacc = 1'b0;
    pacc = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      gi    = a[i-1] & b[i-1];
      pi    = a[i-1] ^ b[i-1];
      gacc  = gi | (pi & gacc);
      pacc  = pi & pacc;
      p[i]  = pi;
      gg[i] = gacc;
      pp[i] = pacc;
    end
  endfunction

  // Reference result: plain integer addition plus signed-overflow rule
  function automatic exp_t model(input logic [15:0] a, input logic [15:0] b, input logic cin);
    exp_t e;
    logic [16:0] full;
    full   = {1'b0, a} + {1'b0, b} + {16'b0, cin};
    e.sum  = full[15:0];
    e.cout = full[16];
    e.ovf  = (a[15] == b[15]) && (full[15] != a[15]);
    e.zero = (full[15:0] == 16'h0000);
    e.neg  = full[15];
    e.cyc  = cyc;
    return e;
  endfunction

  task automatic applyStimulus(input logic [15:0] a, input logic [15:0] b,
                               input logic cin, input logic vld);
    logic [16:1] p, gg, pp;
    derive(a, b, p, gg, pp);
    cur_a    = a;
    cur_b    = b;
    cur_cin  = cin;
    in_p     = p;
    in_G     = gg;
    in_P     = pp;
    in_cin   = cin;
    in_valid = vld;
  endtask

  task automatic applyRandom(input logic vld);
    applyStimulus(16'($urandom()), 16'($urandom()), 1'($urandom()), vld);
  endtask

  // One clock cycle, entered at a falling edge; all sampling happens 1 before the rising edge
  task automatic cycle();
    exp_t e;
    #4;
    last_in_ready  = in_ready;
    last_out_valid = out_valid;
    if (held_valid) begin
      checkOutput("hold_valid", out_valid, 1);
      checkOutput("hold_sum", out_sum, held_sum);
      checkOutput("hold_cout", out_cout, held_cout);
      checkOutput("hold_ovf", out_ovf, held_ovf);
    end
    held_valid = out_valid && !out_ready && !flush;
    held_sum   = out_sum;
    held_cout  = out_cout;
    held_ovf   = out_ovf;
    if (flush) checkOutput("flush_in_ready", in_ready, 0);
    if (out_valid && out_ready) begin
      if (sb.size() == 0) begin
        checkOutput("spurious_out", 1, 0);
      end else begin
        e = sb.pop_front();
        checkOutput("sum", out_sum, e.sum);
        checkOutput("cout", out_cout, e.cout);
        checkOutput("ovf", out_ovf, e.ovf);
`ifdef FLAGS_EN
        checkOutput("zero", out_zero, e.zero);
        checkOutput("neg", out_neg, e.neg);
`endif
        if (strict_lat) checkOutput("latency", cyc - e.cyc, 2);
      end
      exp_count++;
    end
    if (flush) sb.delete();
    if (in_valid && in_ready) sb.push_back(model(cur_a, cur_b, cur_cin));
    checkOutput("occupancy_le2", (sb.size() <= 2) ? 1 : 0, 1);
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic drain(input int limit);
    int n;
    n = 0;
    while (sb.size() > 0 && n < limit) begin
      cycle();
      n++;
    end
    checkOutput("drain_empty", sb.size(), 0);
  endtask

  // Asynchronous reset asserted between edges, entered at a falling edge
  task automatic asyncReset();
    #2 rst_n = 1'b0;
    #1;
    checkOutput("rst_out_valid", out_valid, 0);
    checkOutput("rst_in_ready", in_ready, 0);
    checkOutput("rst_out_sum", out_sum, 0);
    checkOutput("rst_out_cout", out_cout, 0);
    checkOutput("rst_out_ovf", out_ovf, 0);
    checkOutput("rst_op_count", op_count, 0);
`ifdef FLAGS_EN
    checkOutput("rst_out_zero", out_zero, 0);
    checkOutput("rst_out_neg", out_neg, 0);
`endif
    sb.delete();
    exp_count  = '0;
    held_valid = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Watchdog so the run always ends
  initial begin
    #400000;
    $display("[TB] FAIL watchdog: got=timeout want=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Main sequence: reset, directed corners, streaming, backpressure, flush, random, mid-run reset
  initial begin
    logic [CNT_W-1:0] base;
    rst_n      = 1'b0;
    flush      = 1'b0;
    out_ready  = 1'b1;
    held_valid = 1'b0;
    strict_lat = 1'b1;
    exp_count  = '0;
    applyStimulus(16'h0, 16'h0, 1'b0, 1'b0);

    @(negedge clk);
    #4;
    checkOutput("reset_out_valid", out_valid, 0);
    checkOutput("reset_in_ready", in_ready, 0);
    checkOutput("reset_out_sum", out_sum, 0);
    checkOutput("reset_out_cout", out_cout, 0);
    checkOutput("reset_out_ovf", out_ovf, 0);
    checkOutput("reset_op_count", op_count, 0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);

    // 0xFFFF + 0x0001: wraps to zero with carry-out, no signed overflow
    applyStimulus(16'hFFFF, 16'h0001, 1'b0, 1'b1);
    cycle();
    applyStimulus(16'h0, 16'h0, 1'b0, 1'b0);
    cycle();
    checkOutput("d1_valid", out_valid, 1);
    checkOutput("d1_sum", out_sum, 16'h0000);
    checkOutput("d1_cout", out_cout, 1);
    checkOutput("d1_ovf", out_ovf, 0);
`ifdef FLAGS_EN
    checkOutput("d1_zero", out_zero, 1);
`endif
    cycle();

    // 0x7FFF + 0x0001: positive overflow into the sign bit
    applyStimulus(16'h7FFF, 16'h0001, 1'b0, 1'b1);
    cycle();
    applyStimulus(16'h0, 16'h0, 1'b0, 1'b0);
    cycle();
    checkOutput("d2_valid", out_valid, 1);
    checkOutput("d2_sum", out_sum, 16'h8000);
    checkOutput("d2_cout", out_cout, 0);
    checkOutput("d2_ovf", out_ovf, 1);
`ifdef FLAGS_EN
    checkOutput("d2_neg", out_neg, 1);
`endif
    cycle();
    checkOutput("d_op_count", op_count, exp_count);

    // 1000 back-to-back operands with the sink always ready
    base = exp_count;
    for (int k = 0; k < 1000; k++) begin
      applyRandom(1'b1);
      cycle();
      checkOutput("stream_in_ready", last_in_ready, 1);
    end
    applyStimulus(16'h0, 16'h0, 1'b0, 1'b0);
    drain(10);
    checkOutput("stream_results", exp_count - base, 1000);
    checkOutput("stream_op_count", op_count, exp_count);

    // Backpressure: three offered, two taken, then release
    strict_lat = 1'b0;
    out_ready  = 1'b0;
    base       = exp_count;
    applyRandom(1'b1);
    cycle();
    applyRandom(1'b1);
    cycle();
    applyRandom(1'b1);
    for (int k = 0; k < 3; k++) begin
      cycle();
      checkOutput("bp_in_ready", last_in_ready, 0);
    end
    checkOutput("bp_accepted", sb.size(), 2);
    out_ready = 1'b1;
    cycle();
    checkOutput("bp_third_taken", last_in_ready, 1);
    applyStimulus(16'h0, 16'h0, 1'b0, 1'b0);
    drain(10);
    checkOutput("bp_results", exp_count - base, 3);
    checkOutput("bp_op_count", op_count, exp_count);

    // Flush with both stages full and the sink stalled
    out_ready = 1'b0;
    applyRandom(1'b1);
    cycle();
    applyRandom(1'b1);
    cycle();
    base  = op_count;
    flush = 1'b1;
    applyRandom(1'b1);
    cycle();
    flush = 1'b0;
    applyStimulus(16'h0, 16'h0, 1'b0, 1'b0);
    cycle();
    checkOutput("flush_out_valid", last_out_valid, 0);
    checkOutput("flush_in_ready_after", last_in_ready, 1);
    checkOutput("flush_op_count", op_count, exp_count);
    checkOutput("flush_op_count_same", op_count, base);
    out_ready = 1'b1;

    // Flush while a result leaves: that result is still counted
    applyRandom(1'b1);
    cycle();
    applyRandom(1'b1);
    cycle();
    flush = 1'b1;
    cycle();
    flush = 1'b0;
    applyStimulus(16'h0, 16'h0, 1'b0, 1'b0);
    cycle();
    checkOutput("flush2_out_valid", last_out_valid, 0);
    checkOutput("flush2_op_count", op_count, exp_count);

    // Random traffic with random backpressure and occasional flush
    for (int k = 0; k < 400; k++) begin
      applyRandom(($urandom_range(0, 99) < 70) ? 1'b1 : 1'b0);
      out_ready = ($urandom_range(0, 99) < 60) ? 1'b1 : 1'b0;
      flush     = ($urandom_range(0, 99) < 2) ? 1'b1 : 1'b0;
      cycle();
    end
    flush     = 1'b0;
    out_ready = 1'b1;
    applyStimulus(16'h0, 16'h0, 1'b0, 1'b0);
    drain(10);
    checkOutput("rand_op_count", op_count, exp_count);

    // Asynchronous reset in the middle of a stream
    strict_lat = 1'b1;
    for (int k = 0; k < 5; k++) begin
      applyStimulus(16'h1234 + 16'(k), 16'h0101, 1'b1, 1'b1);
      cycle();
    end
    applyStimulus(16'h0, 16'h0, 1'b0, 1'b0);
    asyncReset();
    applyStimulus(16'h00FF, 16'h0F01, 1'b1, 1'b1);
    cycle();
    applyStimulus(16'h0, 16'h0, 1'b0, 1'b0);
    cycle();
    checkOutput("post_rst_valid", out_valid, 1);
    checkOutput("post_rst_sum", out_sum, 16'h1001);
    drain(10);
    checkOutput("post_rst_op_count", op_count, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
